pc_fetch_stage: RTL

- Program-counter register and instruction-fetch stage of the pipelined MIPS datapath.
- Consumes the next-PC target produced by the branch/jump target adder (branch offset add, jr register, j address) together with a redirect strobe.
- Drives the synchronous-read instruction memory and loads the IF/ID pipeline register.
- Handles the one-cycle memory latency, hazard stalls and wrong-path squash on redirect.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/pc_fetch_if_id_reg.sv | 35 +++
 rtl/pc_fetch_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state codes,
// the bubble instruction word, the word size and a target alignment helper.
package fetch_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Branch/jump targets are forced onto a word boundary before use.
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_if_id_reg.sv
// IF/ID pipeline register. A bubble overrides a load; with neither
// asserted the register holds its contents (used for hazard stalls).
module if_id_reg import fetch_pkg::*; #(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] nextPc4,
  input  logic [31:0] nextInstr,
  input  logic        nextValid,
  output logic [31:0] pc4,
  output logic [31:0] instr,
  output logic        valid
);

  // Bubble, load or hold the decode-stage instruction slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc4   <= 32'h0;
      instr <= NOP;
      valid <= 1'b0;
    end else if (bubble) begin
      pc4   <= 32'h0;
      instr <= NOP;
      valid <= 1'b0;
    end else if (load) begin
      pc4   <= nextPc4;
      instr <= nextInstr;
      valid <= nextValid;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Program counter and instruction-fetch stage of the pipelined MIPS datapath.
// The instruction memory answers one cycle after an enabled request, so the
// address of last cycle's request is remembered (reqPc/reqValid) and paired
// with IMemData when IF/ID is loaded. A redirect squashes the in-flight
// request and spends one cycle (S_REDIR) issuing the target.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/squash/stall counters.
module pc_fetch_stage import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] TargetAddr,
  input  logic [31:0] IMemData,
  output logic [31:0] IMemAddr,
  output logic        IMemEn,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
  output logic        Misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [15:0] SquashCount,
  output logic [15:0] StallCount
`endif
);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] reqPc;
  logic        reqValid;
  logic        misalignReg;

  logic        active;
  logic        takeRedirect;
  logic        takeStall;
  logic        advance;
  logic        ifLoad;
  logic        ifBubble;

  // Decode this cycle's action: redirect beats stall beats advance; the
  // idle cycle after reset ignores both and only primes the pipeline.
  always_comb begin
    active       = (state != S_IDLE);
    takeRedirect = active & Redirect;
    takeStall    = active & ~Redirect & Stall;
    advance      = active & ~Redirect & ~Stall;
    ifLoad       = advance & (state == S_FETCH);
    ifBubble     = (state == S_IDLE) | takeRedirect | (advance & (state == S_REDIR));
  end

  assign IMemAddr = pc;
  assign IMemEn   = advance;
  assign Misalign = misalignReg;

  // PC, outstanding-request tracking and FSM sequencing.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      reqPc    <= 32'h0;
      reqValid <= 1'b0;
    end else if (state == S_IDLE) begin
      state <= S_FETCH;
    end else if (takeRedirect) begin
      pc       <= wordAlign(TargetAddr);
      reqValid <= 1'b0;
      state    <= S_REDIR;
    end else if (advance) begin
      reqPc    <= pc;
      reqValid <= 1'b1;
      pc       <= pc + WORD_BYTES;
      state    <= S_FETCH;
    end
  end

  // One-cycle flag for an accepted target with low address bits set.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      misalignReg <= 1'b0;
    end else begin
      misalignReg <= takeRedirect & (TargetAddr[1:0] != 2'b00);
    end
  end

  if_id_reg #(
    .NOP(NOP_INSTR)
  ) ifIdReg (
    .clk      (Clk),
    .rst      (Reset),
    .load     (ifLoad),
    .bubble   (ifBubble),
    .nextPc4  (reqPc + WORD_BYTES),
    .nextInstr(IMemData),
    .nextValid(reqValid),
    .pc4      (IF_ID_PC4),
    .instr    (IF_ID_Instr),
    .valid    (IF_ID_Valid)
  );

`ifdef FETCH_PERF_CNT_EN
  // Free-running event counters; they wrap without saturating.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      FetchCount  <= 32'h0;
      SquashCount <= 16'h0;
      StallCount  <= 16'h0;
    end else begin
      if (ifLoad & reqValid) begin
        FetchCount <= FetchCount + 32'd1;
      end
      if (takeRedirect | (advance & (state == S_REDIR))) begin
        SquashCount <= SquashCount + 16'd1;
      end
      if (takeStall) begin
        StallCount <= StallCount + 16'd1;
      end
    end
  end
`endif

endmodule
